// File: rtl/mac_result_collector.sv
// mac_result_collector
// Watches the running accumulator of an upstream 8-bit MAC. On `start` it
// snapshots the accumulator as a base. It then counts `len` products and
// captures the accumulator delta, which is one dot product. Each result is
// queued in a small first-word-fall-through FIFO for a valid/ready consumer.
//
// Handshake: a result transfers at a rising edge where res_valid and
// res_ready are both 1. res_valid depends only on FIFO occupancy, never on
// res_ready. res_data is held stable while res_valid=1 and no pop occurs.
//
// DEPTH must be a power of two >= 2, so the pointers wrap naturally.
module mac_result_collector #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                mac_out,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  input  logic                       ovf_clr,
  input  logic                       res_ready,
  output logic [15:0]                res_data,
  output logic                       res_valid,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      base;
  logic [15:0]      result;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic push, pop, full, push_ok, drop, last;

  assign last      = (cnt == len_q);
  assign push      = (state == STORE);
  assign full      = (count == CW'(DEPTH));
  assign pop       = res_valid && res_ready;
  // A full FIFO still accepts the push when the head leaves at the same edge.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;

  assign res_valid = (count != '0);
  assign res_data  = mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // State register; reset aborts any collection in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is simply ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COUNT;
      COUNT:   if (last)  state_nxt = STORE;
      STORE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Collection datapath: snapshot base, count products, capture the delta.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      len_q  <= '0;
      base   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base  <= mac_out;
            // A zero length is treated as a single product.
            len_q <= (len == '0) ? LEN_W'(1) : len;
            cnt   <= LEN_W'(1);
          end
        end
        COUNT: begin
          if (last) result <= mac_out - base;
          else      cnt    <= cnt + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

  // Sticky overflow; a new drop wins over a same-edge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed testbench for mac_result_collector (DEPTH=4, LEN_W=4).
module tb_mac_result_collector;

  logic        clk;
  logic        reset;
  logic [15:0] mac_out;
  logic        start;
  logic [3:0]  len;
  logic        ovf_clr;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_valid;
  logic        busy;
  logic        overflow;
  logic [2:0]  count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  mac_result_collector #(.DEPTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mac_out   (mac_out),
    .start     (start),
    .len       (len),
    .ovf_clr   (ovf_clr),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .busy      (busy),
    .overflow  (overflow),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: run one dot product. Returns with the DUT in STORE, before the
  // push edge, so the caller controls res_ready/ovf_clr for that edge.
  task automatic run_dot(input logic [15:0] b, input logic [15:0] c, input int l);
    int lq;
    lq = (l == 0) ? 1 : l;
    mac_out = b;
    len     = 4'(l);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < lq; i++) begin
      mac_out = 16'($urandom_range(0, 65535));
      tick();
    end
    mac_out = c;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; mac_out = '0; start = 1'b0; len = '0;
    ovf_clr = 1'b0; res_ready = 1'b0;
    #3;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_basic();
    mac_out = 16'd100; len = 4'd3; start = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || state_dbg !== 2'd1) begin errors++; $display("FAIL basic_count_state: got busy=%b state=%0d expected busy=1 state=1", busy, state_dbg); end
    // This start arrives in COUNT and must not rebase the collection.
    mac_out = 16'd120; start = 1'b1;
    tick();
    start = 1'b0; mac_out = 16'd140;
    tick();
    mac_out = 16'd160;
    tick();
    checks++; if (state_dbg !== 2'd2 || res_valid !== 1'b0) begin errors++; $display("FAIL basic_store_state: got state=%0d valid=%b expected state=2 valid=0", state_dbg, res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 16'd60) begin errors++; $display("FAIL basic_result: got valid=%b data=%0d expected valid=1 data=60", res_valid, res_data); end
    checks++; if (busy !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL basic_idle: got busy=%b count=%0d expected busy=0 count=1", busy, count); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL basic_pop: got valid=%b count=%0d expected valid=0 count=0", res_valid, count); end
  endtask

  task automatic test_wrap();
    run_dot(16'hFFF0, 16'h0010, 1);
    tick();
    checks++; if (res_data !== 16'h0020 || res_valid !== 1'b1) begin errors++; $display("FAIL wrap_data: got %h valid=%b expected 0020 valid=1", res_data, res_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", overflow); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int k = 1; k <= 5; k++) begin
      run_dot(16'(k * 300), 16'(k * 300 + k), 2);
      tick();
    end
    checks++; if (count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL full_state: got count=%0d ovf=%b expected count=4 ovf=1", count, overflow); end
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 16'(k)) begin errors++; $display("FAIL full_drain: got valid=%b data=%0d expected valid=1 data=%0d", res_valid, res_data, k); end
      tick();
    end
    res_ready = 1'b0;
    checks++; if (count !== 3'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got count=%0d valid=%b expected count=0 valid=0", count, res_valid); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_concurrent_pop();
    for (int k = 1; k <= 4; k++) begin
      run_dot(16'(k * 1000), 16'(k * 1000 + k * 10), 1);
      tick();
    end
    run_dot(16'd500, 16'd550, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL conc_state: got count=%0d ovf=%b expected count=4 ovf=0", count, overflow); end
    res_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      checks++; if (res_data !== 16'(k * 10)) begin errors++; $display("FAIL conc_drain: got %0d expected %0d", res_data, k * 10); end
      tick();
    end
    res_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL conc_empty: got count=%0d expected 0", count); end
  endtask

  task automatic test_ovf_clr();
    for (int k = 1; k <= 4; k++) begin
      run_dot(16'd40000, 16'(40000 + k), 3);
      tick();
    end
    run_dot(16'd7, 16'd12, 1);
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    run_dot(16'd7, 16'd13, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop: got %b expected 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_alone: got %b expected 0", overflow); end
    checks++; if (count !== 3'd4 || res_data !== 16'd1) begin errors++; $display("FAIL ovf_contents: got count=%0d head=%0d expected count=4 head=1", count, res_data); end
    run_dot(16'd7, 16'd14, 1);
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_reset_again: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid_op();
    mac_out = 16'd500; len = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL rst_mid_busy: got busy=%b state=%0d expected busy=0 state=0", busy, state_dbg); end
    checks++; if (res_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_fifo: got valid=%b count=%0d ovf=%b expected 0/0/0", res_valid, count, overflow); end
    tick();
    reset = 1'b1;
    run_dot(16'd1000, 16'd1007, 0);
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL rst_len0_state: got %0d expected 2", state_dbg); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 16'd7) begin errors++; $display("FAIL rst_len0_data: got valid=%b data=%0d expected valid=1 data=7", res_valid, res_data); end
    tick(); tick(); tick();
    checks++; if (count !== 3'd1 || busy !== 1'b0) begin errors++; $display("FAIL rst_one_result: got count=%0d busy=%b expected count=1 busy=0", count, busy); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_single_entry_swap();
    run_dot(16'd200, 16'd205, 1);
    tick();
    checks++; if (count !== 3'd1 || res_data !== 16'd5) begin errors++; $display("FAIL swap_first: got count=%0d data=%0d expected count=1 data=5", count, res_data); end
    run_dot(16'd300, 16'd309, 2);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_data !== 16'd9 || count !== 3'd1) begin errors++; $display("FAIL swap_new: got valid=%b data=%0d count=%0d expected valid=1 data=9 count=1", res_valid, res_data, count); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL swap_empty: got count=%0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_concurrent_pop();
    test_ovf_clr();
    test_reset_mid_op();
    test_single_entry_swap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO depth in entries (power of two).
REQ-002 Parameter LEN_W, default 4, width of the product-count field.
REQ-003 The block SHALL have a single clock `clk`, input, 1 bit; all state is rising-edge triggered.
REQ-004 Reset `reset`, input, 1 bit, SHALL be asynchronous and active-low (0 = reset asserted).
REQ-005 `mac_out`, input, 16 bits, SHALL carry the running accumulator output of the upstream 8-bit MAC.
REQ-006 `start`, input, 1 bit, SHALL be a one-cycle request to begin collecting one dot product.
REQ-007 `len`, input, LEN_W bits, SHALL give the number of MAC products in the dot product; it is sampled with `start`.
REQ-008 `ovf_clr`, input, 1 bit, SHALL clear the sticky overflow flag.
REQ-009 `res_ready`, input, 1 bit, SHALL be the downstream consumer's ready signal.
REQ-010 `res_data`, output, 16 bits, SHALL present the FIFO head result.
REQ-011 `res_valid`, output, 1 bit, SHALL be high whenever the FIFO holds one or more entries.
REQ-012 `busy`, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-013 `overflow`, output, 1 bit, SHALL be a sticky flag indicating that a result was dropped.
REQ-014 `count`, output, $clog2(DEPTH)+1 bits, SHALL report the current FIFO occupancy.

Function
REQ-015 FSM states SHALL be IDLE, COUNT and STORE.
REQ-016 In IDLE, `start`=1 at an edge SHALL cause the following in that cycle:
- base <= `mac_out`
- len_q <= max(`len`,1), so `len`=0 is treated as 1
- cnt <= 1
- transition to COUNT.
REQ-017 `start` SHALL be ignored outside IDLE, with no queuing and no error flag.
REQ-018 In COUNT, at each edge:
- if cnt == len_q: result <= (`mac_out` - base) mod 2^16, then go to STORE
- else: cnt <= cnt+1.
REQ-019 In STORE, at the next edge:
- push the result into the FIFO
- return to IDLE.
REQ-020 Latency: the result SHALL be visible on `res_data` with `res_valid`=1 after edge start+len_q+1, provided the FIFO was empty.
REQ-021 The subtraction SHALL wrap modulo 2^16; no saturation and no wrap flag.
REQ-022 The FIFO SHALL be first-word-fall-through: `res_data` = oldest entry, and it is undefined while `res_valid`=0.
REQ-023 A pop SHALL occur at an edge where `res_valid`=1 and `res_ready`=1.
REQ-024 A push while full SHALL succeed if a pop occurs at the same edge; `count` is then unchanged.
REQ-025 A push while full with no pop SHALL drop the result, set `overflow`=1, and leave FIFO contents and `count` unchanged.
REQ-026 A simultaneous push and pop when `count`=1 SHALL leave `res_valid`=1 and present the new entry next cycle.
REQ-027 `ovf_clr` SHALL clear `overflow`; if `ovf_clr` and a new drop occur at the same edge, `overflow` SHALL end at 1.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 `reset`=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE
- cnt, base, result and pointers = 0
- `count`=0, `res_valid`=0, `busy`=0, `overflow`=0.
REQ-030 Reset asserted mid-COUNT or mid-STORE SHALL abort the collection and push nothing.
REQ-031 After release, the first `start` SHALL be accepted at the first rising edge where `reset`=1.

Verification
REQ-032 Basic: `mac_out`=100 at start, `len`=3, `mac_out`=160 at capture edge -> `res_data`=60, `res_valid`=1 after edge start+4, `busy` low thereafter.
REQ-033 Wrap: base 16'hFFF0, capture 16'h0010 -> `res_data`=16'h0020, `overflow`=0.
REQ-034 Full: five dot products (results 1..5) with `res_ready`=0 -> `count`=4, `overflow`=1; then drain with `res_ready`=1 -> outputs 1,2,3,4 in order, `count`=0.
REQ-035 Full with concurrent pop: FIFO holds 4 entries, `res_ready`=1 at the STORE edge -> new result accepted, `count` stays 4, `overflow`=0.
REQ-036 Reset mid-operation: `reset`=0 during COUNT with `len`=5 -> outputs zero immediately; after release, one fresh start with `len`=0 (treated as 1) -> exactly one result equal to the one-cycle `mac_out` delta.
